// File: rtl/regdump_pkg.sv
// regdump_pkg: shared state encoding and default sizes for the register dumper
package regdump_pkg;
    localparam int REGDUMP_NUM_REGS = 32;
    localparam int REGDUMP_ADDR_W   = 5;
    localparam int REGDUMP_DATA_W   = 32;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;
endpackage

// File: rtl/regfile_dumper.sv
// regfile_dumper: walks every register through an async read port and streams idx/data beats
module regfile_dumper
    import regdump_pkg::*;
#(
    parameter int NUM_REGS = REGDUMP_NUM_REGS,
    parameter int ADDR_W   = REGDUMP_ADDR_W,
    parameter int DATA_W   = REGDUMP_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_out_idx;
    logic [DATA_W-1:0] r_out_data;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
    // idx only changes on entry to READ, so it doubles as the held read address
    assign rd_addr   = r_idx;
    assign out_valid = r_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_out_idx  <= '0;
            r_out_data <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: if (start) begin
                        r_idx   <= '0;
                        r_state <= S_READ;
                        r_busy  <= 1'b1;
                    end
                    S_READ: begin
                        r_out_data <= rd_data;
                        r_out_idx  <= r_idx;
                        r_last     <= r_idx == LAST;
                        r_valid    <= 1'b1;
                        r_state    <= S_HOLD;
                    end
                    S_HOLD: if (out_ready) begin
                        r_valid <= 1'b0;
                        if (r_idx == LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + ADDR_W'(1);
                            r_state <= S_READ;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
